elc_request_scheduler: RTL and testbench

Hall/car call scheduler for the 8-floor elevator car controller. It latches floor calls into a pending set and picks the next target floor using the SCAN policy: keep going in the current direction, reverse only when nothing is pending ahead. It drives the car controller's one-hot request floor and sequences door dwell between stops. It sits between the call buttons and the car controller, which steps one floor per move and reports arrival on its complete flag.

---
 rtl/elc_request_scheduler_if.sv | 30 +++
 rtl/elc_request_scheduler.sv | 180 ++++++++++++++++++
 tb/tb_elc_request_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/elc_request_scheduler_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// elc_request_scheduler_if : call / car / target bundle around the scheduler
// rev 1.0
// ----------------------------------------------------------------------------
interface elc_request_scheduler_if #(
  parameter int NUM_FLOORS = 8
);
  logic [NUM_FLOORS-1:0] call_req;
  logic [NUM_FLOORS-1:0] car_floor;
  logic                  car_complete;
  logic                  hold;
  logic [NUM_FLOORS-1:0] target_floor;
  logic                  target_valid;
  logic                  direction;
  logic                  door_open;
  logic [NUM_FLOORS-1:0] pending;
  logic                  error;

  modport master (
    output call_req, car_floor, car_complete, hold,
    input  target_floor, target_valid, direction, door_open, pending, error
  );

  modport slave (
    input  call_req, car_floor, car_complete, hold,
    output target_floor, target_valid, direction, door_open, pending, error
  );
endinterface
`default_nettype wire

// File: rtl/elc_request_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// elc_request_scheduler : SCAN call scheduler with door dwell sequencing
// rev 1.0
// ----------------------------------------------------------------------------
module elc_request_scheduler #(
  parameter int NUM_FLOORS   = 8,
  parameter int DWELL_CYCLES = 16
) (
  input  wire logic              clk,
  input  wire logic              reset,
  elc_request_scheduler_if.slave sched
);
  localparam int                    TW         = $clog2(DWELL_CYCLES + 1);
  localparam logic [1:0]            S_IDLE     = 2'd0;
  localparam logic [1:0]            S_MOVING   = 2'd1;
  localparam logic [1:0]            S_DWELL    = 2'd2;
  localparam logic [TW-1:0]         DWELL_LOAD = TW'(DWELL_CYCLES);
  localparam logic [NUM_FLOORS-1:0] ONE        = NUM_FLOORS'(1);

  function automatic logic [NUM_FLOORS-1:0] f_lowest(input logic [NUM_FLOORS-1:0] x);
    return x & (~x + ONE);
  endfunction

  function automatic logic [NUM_FLOORS-1:0] f_highest(input logic [NUM_FLOORS-1:0] x);
    logic [NUM_FLOORS-1:0] h;
    h = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (x[i]) h = ONE << i;
    end
    return h;
  endfunction

  logic [1:0]            r_state, w_state_nxt;
  logic [NUM_FLOORS-1:0] r_pending, r_target;
  logic                  r_target_valid, r_dir, r_door_open, r_error;
  logic [TW-1:0]         r_timer;

  logic [NUM_FLOORS-1:0] w_car, w_car_below, w_car_above, w_tgt_below, w_tgt_above;
  logic [NUM_FLOORS-1:0] w_pend_below, w_pend_above, w_sel, w_between, w_retarget;
  logic [NUM_FLOORS-1:0] w_clear, w_pending_nxt, w_target_nxt;
  logic                  w_car_onehot, w_here, w_sel_dir, w_dispatch, w_arrive;
  logic                  w_absorb, w_expire;
  logic                  w_tvalid_nxt, w_dir_nxt, w_door_nxt, w_error_nxt;
  logic [TW-1:0]         w_timer_nxt;

  // One-hot floor arithmetic: (x - 1) masks every floor below x.
  assign w_car        = sched.car_floor;
  assign w_car_onehot = (w_car != '0) && ((w_car & (w_car - ONE)) == '0);
  assign w_car_below  = w_car - ONE;
  assign w_car_above  = ~(w_car | w_car_below);
  assign w_tgt_below  = r_target - ONE;
  assign w_tgt_above  = ~(r_target | w_tgt_below);
  assign w_pend_below = r_pending & w_car_below;
  assign w_pend_above = r_pending & w_car_above;
  assign w_here       = (r_pending & w_car) != '0;
  assign w_dispatch   = (r_pending != '0) && !sched.hold;
  assign w_arrive     = sched.car_complete && (w_car == r_target);
  assign w_absorb     = (sched.call_req & w_car) != '0;
  assign w_expire     = !w_absorb && !sched.hold && (r_timer == TW'(1));
  assign w_between    = r_dir ? (r_pending & w_car_above & w_tgt_below)
                              : (r_pending & w_car_below & w_tgt_above);
  assign w_retarget   = r_dir ? f_lowest(w_between) : f_highest(w_between);

  always_comb begin
    w_sel     = '0;
    w_sel_dir = r_dir;
    if (w_here) begin
      w_sel = w_car;
    end else if (r_dir) begin
      if (w_pend_above != '0) begin
        w_sel = f_lowest(w_pend_above);
      end else begin
        w_sel     = f_highest(w_pend_below);
        w_sel_dir = 1'b0;
      end
    end else begin
      if (w_pend_below != '0) begin
        w_sel = f_highest(w_pend_below);
      end else begin
        w_sel     = f_lowest(w_pend_above);
        w_sel_dir = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_dispatch && w_car_onehot) w_state_nxt = w_here ? S_DWELL : S_MOVING;
      S_MOVING: if (w_arrive) w_state_nxt = S_DWELL;
      S_DWELL:  if (w_expire) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_clear      = '0;
    w_target_nxt = r_target;
    w_tvalid_nxt = r_target_valid;
    w_dir_nxt    = r_dir;
    w_door_nxt   = r_door_open;
    w_error_nxt  = r_error;
    w_timer_nxt  = r_timer;
    case (r_state)
      S_IDLE: begin
        if (w_dispatch) begin
          if (!w_car_onehot) begin
            w_error_nxt = 1'b1;
          end else if (w_here) begin
            w_clear     = w_car;
            w_door_nxt  = 1'b1;
            w_timer_nxt = DWELL_LOAD;
          end else begin
            w_target_nxt = w_sel;
            w_tvalid_nxt = 1'b1;
            w_dir_nxt    = w_sel_dir;
          end
        end
      end
      S_MOVING: begin
        if (w_arrive) begin
          w_clear      = w_car;
          w_target_nxt = '0;
          w_tvalid_nxt = 1'b0;
          w_door_nxt   = 1'b1;
          w_timer_nxt  = DWELL_LOAD;
        end else if (w_between != '0) begin
          w_target_nxt = w_retarget;
        end
      end
      S_DWELL: begin
        if (w_absorb) begin
          w_clear     = sched.call_req & w_car;
          w_timer_nxt = DWELL_LOAD;
        end else if (!sched.hold) begin
          w_timer_nxt = r_timer - TW'(1);
          if (w_expire) w_door_nxt = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Clear beats a same-cycle call on the same floor.
  assign w_pending_nxt = (r_pending | sched.call_req) & ~w_clear;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending      <= '0;
      r_target       <= '0;
      r_target_valid <= 1'b0;
      r_dir          <= 1'b1;
      r_door_open    <= 1'b0;
      r_error        <= 1'b0;
      r_timer        <= '0;
    end else begin
      r_pending      <= w_pending_nxt;
      r_target       <= w_target_nxt;
      r_target_valid <= w_tvalid_nxt;
      r_dir          <= w_dir_nxt;
      r_door_open    <= w_door_nxt;
      r_error        <= w_error_nxt;
      r_timer        <= w_timer_nxt;
    end
  end

  assign sched.target_floor = r_target;
  assign sched.target_valid = r_target_valid;
  assign sched.direction    = r_dir;
  assign sched.door_open    = r_door_open;
  assign sched.pending      = r_pending;
  assign sched.error        = r_error;
endmodule
`default_nettype wire

// File: tb/tb_elc_request_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_elc_request_scheduler : vector table, directed corners, random vs floor model
// rev 1.0
// ----------------------------------------------------------------------------
module tb_elc_request_scheduler;
  localparam int DWELL = 16;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  elc_request_scheduler_if #(.NUM_FLOORS(8)) bus ();

  elc_request_scheduler #(.NUM_FLOORS(8), .DWELL_CYCLES(DWELL)) dut (
    .clk   (clk),
    .reset (reset),
    .sched (bus)
  );

  typedef enum int {M_IDLE, M_MOVING, M_DWELL} mstate_t;
  mstate_t m_state = M_IDLE;
  bit      m_pend[8];
  int      m_tgt   = -1;
  bit      m_dir   = 1'b1;
  bit      m_err   = 1'b0;
  int      m_timer = 0;

  typedef struct {
    logic       rst;
    logic [7:0] call;
    logic [7:0] car;
    logic       cmpl;
    logic       hold;
    logic [7:0] e_tgt;
    logic       e_valid;
    logic       e_dir;
    logic       e_door;
    logic [7:0] e_pend;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int car_idx(input logic [7:0] v);
    int n   = 0;
    int idx = -1;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        n++;
        idx = i;
      end
    end
    return (n == 1) ? idx : -1;
  endfunction

  // Nearest pending floor strictly beyond 'from' in the given direction.
  function automatic int nearest(input int from, input bit up);
    if (up) begin
      for (int f = from + 1; f < 8; f++) if (m_pend[f]) return f;
    end else begin
      for (int f = from - 1; f >= 0; f--) if (m_pend[f]) return f;
    end
    return -1;
  endfunction

  task automatic tick();
    bit      np[8];
    mstate_t ns  = m_state;
    int      nt  = m_tgt;
    bit      nd  = m_dir;
    bit      ne  = m_err;
    int      ntm = m_timer;
    int      c   = car_idx(bus.car_floor);
    bit      any = 1'b0;
    int      f;
    logic [7:0] pv;
    logic [7:0] tv;
    for (int i = 0; i < 8; i++) begin
      np[i] = m_pend[i] | bus.call_req[i];
      any   = any | m_pend[i];
    end
    if (reset) begin
      ns = M_IDLE; nt = -1; nd = 1'b1; ne = 1'b0; ntm = 0;
      for (int i = 0; i < 8; i++) np[i] = 1'b0;
    end else begin
      case (m_state)
        M_IDLE: if (any && !bus.hold) begin
          if (c < 0) begin
            ne = 1'b1;
          end else if (m_pend[c]) begin
            ns = M_DWELL; np[c] = 1'b0; ntm = DWELL;
          end else begin
            f = nearest(c, m_dir);
            if (f < 0) begin
              nd = !m_dir;
              f  = nearest(c, nd);
            end
            ns = M_MOVING; nt = f;
          end
        end
        M_MOVING: begin
          if (bus.car_complete && c == m_tgt) begin
            ns = M_DWELL; np[c] = 1'b0; nt = -1; ntm = DWELL;
          end else if (c >= 0) begin
            f = nearest(c, m_dir);
            if (f >= 0 && (m_dir ? (f < m_tgt) : (f > m_tgt))) nt = f;
          end
        end
        default: begin
          if (c >= 0 && bus.call_req[c]) begin
            np[c] = 1'b0; ntm = DWELL;
          end else if (!bus.hold) begin
            if (m_timer == 1) begin
              ns = M_IDLE; ntm = 0;
            end else begin
              ntm = m_timer - 1;
            end
          end
        end
      endcase
    end
    @(posedge clk);
    #1;
    m_state = ns; m_tgt = nt; m_dir = nd; m_err = ne; m_timer = ntm;
    for (int i = 0; i < 8; i++) begin
      m_pend[i] = np[i];
      pv[i]     = np[i];
    end
    tv = (m_tgt < 0) ? 8'h00 : 8'(1 << m_tgt);
    chk("model", {12'h0, bus.target_floor, bus.target_valid, bus.direction, bus.door_open,
                  bus.pending, bus.error},
                 {12'h0, tv, m_state == M_MOVING, m_dir, m_state == M_DWELL, pv, m_err});
  endtask

  task automatic dwell_run(input int hold_at, input int hold_n, input int call_at, output int n);
    n = 0;
    while (bus.door_open && n < 64) begin
      bus.hold         = (n >= hold_at) && (n < hold_at + hold_n);
      bus.call_req     = (n == call_at) ? bus.car_floor : 8'h00;
      bus.car_complete = 1'b0;
      n++;
      tick();
    end
    bus.hold     = 1'b0;
    bus.call_req = 8'h00;
  endtask

  task automatic wait_valid();
    int k = 0;
    while (!bus.target_valid && k < 40) begin
      tick();
      k++;
    end
    chk("wait_valid", bus.target_valid, 1);
  endtask

  task automatic serve(input logic [7:0] exp_t, input logic exp_d);
    int k = 0;
    wait_valid();
    chk("serve_target", bus.target_floor, exp_t);
    chk("serve_dir", bus.direction, exp_d);
    bus.car_floor    = exp_t;
    bus.car_complete = 1'b1;
    tick();
    bus.car_complete = 1'b0;
    chk("serve_door", bus.door_open, 1);
    while (bus.door_open && k < 40) begin
      tick();
      k++;
    end
    chk("serve_close", bus.door_open, 0);
  endtask

  initial begin
    vec_t tbl[6];
    int   n;
    int   c;

    tbl[0] = '{1'b1, 8'h00, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 8'h10, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h10};
    tbl[2] = '{1'b0, 8'h00, 8'h01, 1'b0, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 8'h10};
    tbl[3] = '{1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 8'h10};
    tbl[4] = '{1'b0, 8'h00, 8'h08, 1'b1, 1'b0, 8'h10, 1'b1, 1'b1, 1'b0, 8'h10};
    tbl[5] = '{1'b0, 8'h00, 8'h10, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00};

    reset = 1'b1;
    bus.call_req = 8'h00; bus.car_floor = 8'h01; bus.car_complete = 1'b0; bus.hold = 1'b0;

    for (int i = 0; i < 6; i++) begin
      reset = tbl[i].rst; bus.call_req = tbl[i].call; bus.car_floor = tbl[i].car;
      bus.car_complete = tbl[i].cmpl; bus.hold = tbl[i].hold;
      tick();
      chk($sformatf("tbl%0d_tgt", i),   bus.target_floor, tbl[i].e_tgt);
      chk($sformatf("tbl%0d_valid", i), bus.target_valid, tbl[i].e_valid);
      chk($sformatf("tbl%0d_dir", i),   bus.direction,    tbl[i].e_dir);
      chk($sformatf("tbl%0d_door", i),  bus.door_open,    tbl[i].e_door);
      chk($sformatf("tbl%0d_pend", i),  bus.pending,      tbl[i].e_pend);
      chk($sformatf("tbl%0d_err", i),   bus.error,        1'b0);
    end
    bus.car_complete = 1'b0;
    dwell_run(0, 0, -1, n);
    chk("dwell_len", n, DWELL);

    // Hold in IDLE blocks dispatch; release dispatches with a reversal.
    bus.hold = 1'b1; bus.call_req = 8'h01;
    tick();
    bus.call_req = 8'h00;
    repeat (3) tick();
    chk("hold_idle_valid", bus.target_valid, 0);
    chk("hold_idle_pend", bus.pending, 8'h01);
    bus.hold = 1'b0;
    tick();
    chk("release_valid", bus.target_valid, 1);
    chk("release_tgt", bus.target_floor, 8'h01);
    chk("release_dir", bus.direction, 0);
    bus.car_floor = 8'h01; bus.car_complete = 1'b1;
    tick();
    bus.car_complete = 1'b0;
    dwell_run(3, 5, -1, n);
    chk("hold_dwell_len", n, DWELL + 5);

    // Same-floor call goes straight to DWELL; a repeat reloads the timer.
    bus.car_floor = 8'h04; bus.call_req = 8'h04;
    tick();
    bus.call_req = 8'h00;
    tick();
    chk("same_valid", bus.target_valid, 0);
    chk("same_door", bus.door_open, 1);
    dwell_run(-1, 0, 4, n);
    chk("reload_len", n, 4 + 1 + DWELL);

    // SCAN ordering from a fresh reset.
    reset = 1'b1; bus.car_floor = 8'h04;
    tick();
    reset = 1'b0;
    bus.call_req = 8'hA1;
    tick();
    bus.call_req = 8'h00;
    serve(8'h20, 1'b1);
    serve(8'h80, 1'b1);
    serve(8'h01, 1'b0);

    // Retarget to a call between car and target.
    bus.call_req = 8'h80;
    tick();
    bus.call_req = 8'h00;
    wait_valid();
    chk("rt_first_tgt", bus.target_floor, 8'h80);
    bus.car_floor = 8'h02;
    tick();
    bus.call_req = 8'h08;
    tick();
    bus.call_req = 8'h00;
    tick();
    chk("rt_tgt", bus.target_floor, 8'h08);
    chk("rt_valid", bus.target_valid, 1);
    chk("rt_pend", bus.pending, 8'h88);
    serve(8'h08, 1'b1);
    wait_valid();
    chk("rt_resume_tgt", bus.target_floor, 8'h80);

    // Reset while MOVING.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_outputs", {bus.target_floor, bus.target_valid, bus.direction, bus.door_open,
                        bus.pending, bus.error}, {8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0});

    // Non-one-hot car floor raises a sticky error.
    bus.car_floor = 8'h06; bus.call_req = 8'h01;
    tick();
    bus.call_req = 8'h00;
    tick();
    chk("err_set", bus.error, 1);
    chk("err_no_dispatch", bus.target_valid, 0);
    tick();
    chk("err_sticky", bus.error, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("err_cleared", bus.error, 0);

    // Random traffic against the floor model with an emulated car.
    c = 0;
    bus.car_floor = 8'h01;
    for (int t = 0; t < 3000; t++) begin
      if (m_state == M_MOVING && m_tgt >= 0 && c != m_tgt && $urandom_range(0, 2) == 0)
        c = (m_tgt > c) ? c + 1 : c - 1;
      bus.car_floor    = 8'(1 << c);
      bus.car_complete = (m_state == M_MOVING && c == m_tgt) ? 1'($urandom_range(0, 1))
                                                              : ($urandom_range(0, 9) == 0);
      bus.hold         = ($urandom_range(0, 11) == 0);
      bus.call_req     = ($urandom_range(0, 5) == 0) ? 8'($urandom & $urandom) : 8'h00;
      reset            = ($urandom_range(0, 999) == 0);
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
